seq_detector_prog: RTL and testbench

SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

---
 rtl/seq_detector_prog.sv | 114 +++++++++++
 tb/tb_seq_detector_prog.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Programmable symbol-sequence detector with overlap control and fill tracking.
// Define SEQDET_MATCH_CNT_EN to add the saturating match_cnt output.
module seq_detector_prog #(
  parameter int unsigned DW      = 1,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic [DW-1:0]          d_i,
  input  logic                   cfg_we,
  input  logic [4:0]             cfg_len,
  input  logic [MAX_LEN*DW-1:0]  cfg_pat,
  input  logic                   cfg_ovl,
  output logic                   match_o,
`ifdef SEQDET_MATCH_CNT_EN
  output logic [CNT_W-1:0]       match_cnt,
`endif
  output logic [4:0]             fill_o
);

  localparam logic [4:0] MaxLen = 5'(MAX_LEN);

  typedef logic [DW-1:0] sym_t;

  // Index 0 holds the newest symbol.
  sym_t [MAX_LEN-1:0] hist_q, hist_d, hist_sh;
  sym_t [MAX_LEN-1:0] pat_q, pat_d;
  logic [4:0]         len_q, len_d;
  logic [4:0]         fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               match_q, match_d;
  logic               hit;

  always_comb begin
    hist_sh = {hist_q[MAX_LEN-2:0], d_i};
  end

  // Newest symbol aligns with pattern symbol len-1.
  always_comb begin
    hit = (len_q != 5'd0) && ((int'(fill_q) + 1) >= int'(len_q));
    for (int j = 0; j < int'(MAX_LEN); j++) begin
      for (int k = 0; k < int'(MAX_LEN); k++) begin
        if (((j + k + 1) == int'(len_q)) && (hist_sh[j] != pat_q[k])) begin
          hit = 1'b0;
        end
      end
    end
  end

  always_comb begin
    hist_d  = hist_q;
    pat_d   = pat_q;
    len_d   = len_q;
    fill_d  = fill_q;
    ovl_d   = ovl_q;
    match_d = 1'b0;
    if (cfg_we) begin
      pat_d  = cfg_pat;
      len_d  = (cfg_len > MaxLen) ? MaxLen : cfg_len;
      ovl_d  = cfg_ovl;
      hist_d = '0;
      fill_d = 5'd0;
    end else if (valid_i) begin
      hist_d  = hist_sh;
      match_d = hit;
      if (hit && !ovl_q) begin
        fill_d = 5'd0;
      end else if (fill_q != MaxLen) begin
        fill_d = fill_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      pat_q   <= '0;
      len_q   <= 5'd0;
      fill_q  <= 5'd0;
      ovl_q   <= 1'b1;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
    end
  end

  assign match_o = match_q;
  assign fill_o  = fill_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      cnt_q <= '0;
    end else if (valid_i && hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's outputs,
// a monitor on the falling edge pops and compares.
module tb_seq_detector_prog;

  localparam int unsigned DW      = 1;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  valid_i;
  logic [DW-1:0]         d_i;
  logic                  cfg_we;
  logic [4:0]            cfg_len;
  logic [MAX_LEN*DW-1:0] cfg_pat;
  logic                  cfg_ovl;
  logic                  match_o;
  logic [4:0]            fill_o;
`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0]      match_cnt;
`endif

  seq_detector_prog #(.DW(DW), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .d_i      (d_i),
    .cfg_we   (cfg_we),
    .cfg_len  (cfg_len),
    .cfg_pat  (cfg_pat),
    .cfg_ovl  (cfg_ovl),
    .match_o  (match_o),
`ifdef SEQDET_MATCH_CNT_EN
    .match_cnt(match_cnt),
`endif
    .fill_o   (fill_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          match;
    int          fill;
    longint      cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   obs_matches = 0;

  // Reference model: plain list of accepted symbols, newest at the back.
  int     m_hist[$];
  int     m_fill;
  int     m_len;
  bit     m_ovl;
  int     m_pat[MAX_LEN];
  longint m_cnt;
  localparam longint CntMax = (longint'(1) << CNT_W) - 1;

  function automatic bit tail_matches();
    int n = m_hist.size();
    if (n < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_hist[n - m_len + k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit r, input bit v, input int d, input bit we = 1'b0,
                      input int clen = 0, input logic [MAX_LEN*DW-1:0] cpat = '0,
                      input bit covl = 1'b1);
    exp_t e;
    rst = r; valid_i = v; d_i = DW'(d); cfg_we = we;
    cfg_len = 5'(clen); cfg_pat = cpat; cfg_ovl = covl;
    e.match = 1'b0;
    if (r) begin
      m_hist.delete(); m_fill = 0; m_len = 0; m_ovl = 1'b1; m_cnt = 0;
      for (int i = 0; i < MAX_LEN; i++) m_pat[i] = 0;
    end else if (we) begin
      m_len = (clen > MAX_LEN) ? MAX_LEN : clen;
      m_ovl = covl;
      for (int i = 0; i < MAX_LEN; i++) m_pat[i] = int'(cpat[DW*i +: DW]);
      m_hist.delete(); m_fill = 0; m_cnt = 0;
    end else if (v) begin
      m_hist.push_back(d);
      e.match = (m_len > 0) && (m_fill + 1 >= m_len) && tail_matches();
      if (e.match && m_cnt < CntMax) m_cnt++;
      if (e.match && !m_ovl) m_fill = 0;
      else if (m_fill < MAX_LEN) m_fill++;
      while (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
    end
    e.fill = m_fill;
    e.cnt  = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Send n symbols (bit i of s is beat i), with 'gap' idle cycles between beats.
  task automatic send(input int n, input logic [31:0] s, input int gap = 0);
    logic [31:0] v = s;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, int'(v[i]));
      if (i != n - 1)
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 0);
    end
  endtask

  task automatic cfg(input int len, input logic [MAX_LEN*DW-1:0] pat, input bit ovl);
    step(1'b0, 1'b0, 0, 1'b1, len, pat, ovl);
  endtask

  // Let the monitor consume the last pushed expectation.
  task automatic settle();
    step(1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_count(input string name, input int base, input int want);
    vectors++;
    if (obs_matches - base != want) begin
      miscompares++;
      $display("FAIL %s: observed %0d matches, expected %0d", name, obs_matches - base, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if (match_o === 1'b1) obs_matches++;
        if (match_o !== e.match || fill_o !== 5'(e.fill)) begin
          miscompares++;
          $display("FAIL cycle %0d: match_o=%b fill_o=%0d, expected match_o=%b fill_o=%0d",
                   vectors, match_o, fill_o, e.match, e.fill);
        end
`ifdef SEQDET_MATCH_CNT_EN
        if (match_cnt !== CNT_W'(e.cnt)) begin
          miscompares++;
          $display("FAIL match_cnt: got %0d, expected %0d", match_cnt, e.cnt);
        end
`endif
      end
    end
  end

  initial begin : driver
    int base;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1);

    // Pattern 0,0,1,0,1 with overlap; single match, no false second match.
    cfg(5, 8'b0001_0100, 1'b1);
    base = obs_matches;
    send(5, 32'b10100);
    send(2, 32'b10);
    settle();
    check_count("len5_ovl", base, 1);

    // Pattern 0,1,0,1 with overlap: matches after beats 4 and 6.
    cfg(4, 8'b0000_1010, 1'b1);
    base = obs_matches;
    send(6, 32'b101010);
    settle();
    check_count("len4_ovl", base, 2);

    // Same pattern without overlap: matches after beats 4 and 8 only.
    cfg(4, 8'b0000_1010, 1'b0);
    base = obs_matches;
    send(8, 32'b10101010);
    settle();
    check_count("len4_no_ovl", base, 2);

    // Idle gaps between beats hold history and fill.
    cfg(5, 8'b0001_0100, 1'b1);
    base = obs_matches;
    send(5, 32'b10100, 3);
    settle();
    check_count("gaps", base, 1);

    // Reconfigure mid-pattern: the 5th beat alone must not match.
    base = obs_matches;
    send(4, 32'b0100);
    cfg(5, 8'b0001_0100, 1'b1);
    send(1, 32'b1);
    settle();
    check_count("cfg_mid", base, 0);

    // Length clamp to MAX_LEN.
    cfg(20, 8'b1011_0010, 1'b1);
    base = obs_matches;
    send(10, 32'b10_1011_0010);
    settle();
    check_count("clamp", base, 1);

    // Length 0 disables matching.
    cfg(0, 8'b0000_0000, 1'b1);
    base = obs_matches;
    send(12, 32'h000);
    settle();
    check_count("len0", base, 0);

    // Reset on the completing beat suppresses the pulse.
    cfg(5, 8'b0001_0100, 1'b1);
    send(4, 32'b0100);
    step(1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int sel = int'($urandom_range(0, 99));
      if (sel == 0)
        step(1'b1, 1'b1, int'($urandom_range(0, 1)));
      else if (sel < 4)
        cfg(int'($urandom_range(0, 20)), MAX_LEN'($urandom), 1'($urandom));
      else
        step(1'b0, ($urandom_range(0, 9) < 7), int'($urandom_range(0, (1 << DW) - 1)),
             1'b0, int'($urandom_range(0, 31)), MAX_LEN'($urandom), 1'($urandom));
    end
    settle();

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
